elm_mac_seq: RTL

ELM_MAC_SEQ -- requirements
Module: elm_mac_seq

---
 rtl/elm_pkg.sv | 8 +
 rtl/elm_idx_cnt.sv | 21 ++
 rtl/elm_mac_seq.sv | 71 +++++++
 3 files changed

// File: rtl/elm_pkg.sv
// elm_pkg: state encoding and default sizing shared by the ELM MAC sequencer and its index counter.
package elm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_ACT, S_WR, S_DONE} state_e;
  localparam int N_IN_DEF    = 9;
  localparam int N_HID_DEF   = 16;
  localparam int ACT_LAT_DEF = 2;
  localparam int IDX_W       = 4;
endpackage

// File: rtl/elm_idx_cnt.sv
// elm_idx_cnt: 0..MAX index counter with enable, synchronous clear and terminal-count flag.
module elm_idx_cnt import elm_pkg::*; #(
  parameter int MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             tc_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX);
  logic [IDX_W-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == LAST;
  assign cnt_o = cnt_q;
  // an enabled step at the terminal value returns to zero instead of overrunning the range
  assign cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/elm_mac_seq.sv
// elm_mac_seq: sequences CLR/ACC/ACT/WR per hidden neuron of an ELM hidden layer.
// Outputs are decoded from registered state; mac_en additionally gates on in_ready.
module elm_mac_seq import elm_pkg::*; #(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_HID   = N_HID_DEF,
  parameter int ACT_LAT = ACT_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_ready,
  input  logic             wr_ack,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] in_idx,
  output logic [IDX_W-1:0] hid_idx,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             act_en,
  output logic             wr_en
);
  state_e     state_q, state_d;
  logic [2:0] act_q, act_d;
  logic       in_tc, hid_tc, act_last;
  assign act_last = act_q == 3'(ACT_LAT - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_CLR : S_IDLE;
      S_CLR:   state_d = S_ACC;
      S_ACC:   state_d = (in_ready && in_tc) ? S_ACT : S_ACC;
      S_ACT:   state_d = act_last ? S_WR : S_ACT;
      S_WR:    state_d = wr_ack ? (hid_tc ? S_DONE : S_CLR) : S_WR;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  assign act_d = (state_q == S_ACT && !act_last) ? act_q + 3'd1 : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  elm_idx_cnt #(.MAX(N_IN - 1)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == S_ACC && in_ready),
    .clr_i (abort || state_q == S_IDLE),
    .cnt_o (in_idx),
    .tc_o  (in_tc)
  );
  // the last neuron's ack leaves hid_idx in place; DONE clears it for the next run
  elm_idx_cnt #(.MAX(N_HID - 1)) u_hid_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == S_WR && wr_ack && !hid_tc),
    .clr_i (abort || state_q == S_IDLE || state_q == S_DONE),
    .cnt_o (hid_idx),
    .tc_o  (hid_tc)
  );
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign mac_clr = state_q == S_CLR;
  assign mac_en  = state_q == S_ACC && in_ready;
  assign act_en  = state_q == S_ACT && act_q == '0;
  assign wr_en   = state_q == S_WR;
endmodule
